// File: rtl/syn_updown_counter_param.sv
// -----------------------------------------------------------------------------
// syn_updown_counter_param
//
// Parametrised synchronous up/down counter with a runtime terminal value.
// The count range is 0..limit. When the count runs past either end it either
// wraps to the other end or holds there, depending on SATURATE. Either case
// raises a one-cycle registered event pulse.
//
// Parameters:
//   WIDTH     - counter width in bits (>= 1)
//   SATURATE  - 0: wrap at the terminal values, 1: hold at the terminal values
//   RESET_VAL - value forced into q while clear is high (not clamped to limit)
//
// Ports:
//   clk     in   rising-edge clock
//   clear   in   asynchronous active-high reset
//   en      in   count enable (0 = hold)
//   M       in   direction: 1 = up, 0 = down
//   load    in   synchronous parallel load strobe (beats en)
//   din     in   parallel load value (clamped to limit)
//   limit   in   terminal (maximum) count
//   q       out  registered count
//   at_max  out  combinational, q == limit
//   at_zero out  combinational, q == 0
//   evt     out  registered pulse on a wrap or a blocked count
// -----------------------------------------------------------------------------
module syn_updown_counter_param #(
  parameter int unsigned          WIDTH     = 3,
  parameter bit                   SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             M,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             at_max,
  output logic             at_zero,
  output logic             evt
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] q_q, q_d;
  logic             evt_q, evt_d;

  // Next-state logic. Priority: load > en > hold. clear is handled
  // asynchronously in the register block.
  always_comb begin
    q_d   = q_q;
    evt_d = 1'b0;
    if (load) begin
      q_d = (din > limit) ? limit : din;
    end else if (en) begin
      if (M) begin
        if (q_q < limit) begin
          q_d = q_q + ONE;
        end else begin
          // At or above the terminal value (limit may have been lowered at
          // runtime): the increment is either wrapped or blocked.
          evt_d = 1'b1;
          q_d   = SATURATE ? limit : ZERO;
        end
      end else begin
        if (q_q > limit) begin
          // limit was lowered below q: pull q back into range, no event.
          q_d = limit;
        end else if (q_q != ZERO) begin
          q_d = q_q - ONE;
        end else begin
          evt_d = 1'b1;
          q_d   = SATURATE ? ZERO : limit;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q_q   <= RESET_VAL;
      evt_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      evt_q <= evt_d;
    end
  end

  assign q       = q_q;
  assign evt     = evt_q;
  assign at_max  = (q_q == limit);
  assign at_zero = (q_q == ZERO);

endmodule

// File: tb/tb_syn_updown_counter_param.sv
// -----------------------------------------------------------------------------
// tb_syn_updown_counter_param
//
// Two counters share the same inputs: one that wraps (RESET_VAL = 0) and one
// that saturates (RESET_VAL = 1). Directed vectors with hand-computed
// expected values; inputs change 1 time unit after each rising edge, and
// outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_syn_updown_counter_param;

  logic       clk;
  logic       clear;
  logic       en;
  logic       M;
  logic       load;
  logic [2:0] din;
  logic [2:0] limit;

  logic [2:0] qw, qs;
  logic       at_max_w, at_zero_w, evt_w;
  logic       at_max_s, at_zero_s, evt_s;

  int total = 0;
  int bad   = 0;

  logic [2:0] exp_q[$];

  syn_updown_counter_param #(
    .WIDTH(3), .SATURATE(1'b0), .RESET_VAL(3'd0)
  ) u_wrap (
    .clk(clk), .clear(clear), .en(en), .M(M), .load(load), .din(din),
    .limit(limit), .q(qw), .at_max(at_max_w), .at_zero(at_zero_w), .evt(evt_w)
  );

  syn_updown_counter_param #(
    .WIDTH(3), .SATURATE(1'b1), .RESET_VAL(3'd1)
  ) u_sat (
    .clk(clk), .clear(clear), .en(en), .M(M), .load(load), .din(din),
    .limit(limit), .q(qs), .at_max(at_max_s), .at_zero(at_zero_s), .evt(evt_s)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_w(input string tag, input logic [2:0] eq, input logic ee);
    step();
    check({tag, "_qw"}, 32'(qw), 32'(eq));
    check({tag, "_evtw"}, 32'(evt_w), 32'(ee));
  endtask

  task automatic step_s(input string tag, input logic [2:0] eq, input logic ee);
    step();
    check({tag, "_qs"}, 32'(qs), 32'(eq));
    check({tag, "_evts"}, 32'(evt_s), 32'(ee));
  endtask

  // Called 1 unit after an edge; clear is high strictly between edges.
  task automatic pulse_clear();
    #2 clear = 1'b1;
    #2 clear = 1'b0;
  endtask

  initial begin
    logic [2:0] e;
    clear = 1'b1;
    en    = 1'b0;
    M     = 1'b1;
    load  = 1'b0;
    din   = 3'd0;
    limit = 3'd7;

    // reset state
    #3;
    check("rst_qw", 32'(qw), 32'd0);
    check("rst_qs", 32'(qs), 32'd1);
    check("rst_evtw", 32'(evt_w), 32'd0);
    check("rst_evts", 32'(evt_s), 32'd0);
    check("rst_atzero_w", 32'(at_zero_w), 32'd1);
    check("rst_atmax_w", 32'(at_max_w), 32'd0);
    check("rst_atzero_s", 32'(at_zero_s), 32'd0);
    en = 1'b1;
    step();
    check("rst_hold_qw", 32'(qw), 32'd0);
    check("rst_hold_qs", 32'(qs), 32'd1);
    clear = 1'b0;

    // wrap, up count 1..7 then 0
    for (int k = 1; k <= 7; k++) exp_q.push_back(3'(k));
    exp_q.push_back(3'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step_w("up", e, (e == 3'd0));
      check("up_atmax", 32'(at_max_w), 32'(e == 3'd7));
    end

    // wrap, down count with a direction toggle at 4
    M = 1'b0;
    step_w("dn7", 3'd7, 1'b1);
    step_w("dn6", 3'd6, 1'b0);
    step_w("dn5", 3'd5, 1'b0);
    step_w("dn4", 3'd4, 1'b0);
    M = 1'b1;
    step_w("tog5", 3'd5, 1'b0);
    M = 1'b0;
    step_w("dn4b", 3'd4, 1'b0);
    step_w("dn3", 3'd3, 1'b0);
    step_w("dn2", 3'd2, 1'b0);
    step_w("dn1", 3'd1, 1'b0);
    step_w("dn0", 3'd0, 1'b0);
    step_w("dnwrap", 3'd7, 1'b1);

    // saturate, limit 5, from RESET_VAL 1
    en = 1'b0;
    pulse_clear();
    limit = 3'd5;
    M     = 1'b1;
    en    = 1'b1;
    step_s("s2", 3'd2, 1'b0);
    step_s("s3", 3'd3, 1'b0);
    step_s("s4", 3'd4, 1'b0);
    step_s("s5", 3'd5, 1'b0);
    step_s("sblk1", 3'd5, 1'b1);
    step_s("sblk2", 3'd5, 1'b1);
    check("s_atmax", 32'(at_max_s), 32'd1);
    M = 1'b0;
    step_s("sd4", 3'd4, 1'b0);
    step_s("sd3", 3'd3, 1'b0);
    step_s("sd2", 3'd2, 1'b0);
    step_s("sd1", 3'd1, 1'b0);
    step_s("sd0", 3'd0, 1'b0);
    step_s("sdblk1", 3'd0, 1'b1);
    step_s("sdblk2", 3'd0, 1'b1);
    check("s_atzero", 32'(at_zero_s), 32'd1);

    // parallel load
    en = 1'b0;
    pulse_clear();
    limit = 3'd5;
    load  = 1'b1;
    din   = 3'd3;
    step_w("ld3", 3'd3, 1'b0);
    load = 1'b0;
    en   = 1'b1;
    M    = 1'b1;
    step_w("ld_up4", 3'd4, 1'b0);
    step_w("ld_up5", 3'd5, 1'b0);
    step_w("ld_wrap", 3'd0, 1'b1);
    load = 1'b1;
    din  = 3'd6;
    step_w("ld_clamp", 3'd5, 1'b0);
    din = 3'd2;
    M   = 1'b0;
    step_w("ld_wins", 3'd2, 1'b0);
    load = 1'b0;

    // runtime limit change
    en    = 1'b0;
    limit = 3'd7;
    load  = 1'b1;
    din   = 3'd6;
    step_w("rl_ld", 3'd6, 1'b0);
    load  = 1'b0;
    limit = 3'd4;
    M     = 1'b0;
    en    = 1'b1;
    step_w("rl_dn4", 3'd4, 1'b0);
    step_w("rl_dn3", 3'd3, 1'b0);
    en    = 1'b0;
    limit = 3'd7;
    load  = 1'b1;
    din   = 3'd6;
    step_s("rl_ld_s", 3'd6, 1'b0);
    load  = 1'b0;
    limit = 3'd4;
    M     = 1'b1;
    en    = 1'b1;
    step();
    check("rl_up_qw", 32'(qw), 32'd0);
    check("rl_up_evtw", 32'(evt_w), 32'd1);
    check("rl_up_qs", 32'(qs), 32'd4);
    check("rl_up_evts", 32'(evt_s), 32'd1);

    // async clear cancels a pending event
    en    = 1'b0;
    limit = 3'd7;
    load  = 1'b1;
    din   = 3'd7;
    step_w("ac_ld", 3'd7, 1'b0);
    load = 1'b0;
    en   = 1'b1;
    M    = 1'b1;
    step();
    check("ac_pre_qw", 32'(qw), 32'd0);
    check("ac_pre_evtw", 32'(evt_w), 32'd1);
    check("ac_pre_evts", 32'(evt_s), 32'd1);
    #2 clear = 1'b1;
    #1;
    check("ac_qs", 32'(qs), 32'd1);
    check("ac_evts", 32'(evt_s), 32'd0);
    check("ac_evtw", 32'(evt_w), 32'd0);
    #1 clear = 1'b0;

    // async clear at q=5, then hold with en=0
    en   = 1'b0;
    load = 1'b1;
    din  = 3'd5;
    step_w("ac5_ld", 3'd5, 1'b0);
    load = 1'b0;
    #2 clear = 1'b1;
    #1;
    check("ac5_qw", 32'(qw), 32'd0);
    check("ac5_qs", 32'(qs), 32'd1);
    #1 clear = 1'b0;
    load = 1'b1;
    step_w("hold_ld", 3'd5, 1'b0);
    load = 1'b0;
    en   = 1'b0;
    M    = 1'b1;
    for (int k = 0; k < 10; k++) step_w("hold", 3'd5, 1'b0);

    // limit = 0
    pulse_clear();
    limit = 3'd0;
    M     = 1'b1;
    en    = 1'b1;
    step();
    check("l0_up_qw", 32'(qw), 32'd0);
    check("l0_up_evtw", 32'(evt_w), 32'd1);
    check("l0_up_qs", 32'(qs), 32'd0);
    check("l0_up_evts", 32'(evt_s), 32'd1);
    check("l0_atmax", 32'(at_max_w), 32'd1);
    check("l0_atzero", 32'(at_zero_w), 32'd1);
    M = 1'b0;
    step();
    check("l0_dn_qw", 32'(qw), 32'd0);
    check("l0_dn_evtw", 32'(evt_w), 32'd1);
    check("l0_dn_qs", 32'(qs), 32'd0);
    check("l0_dn_evts", 32'(evt_s), 32'd1);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
